row_matrix_stream_pu: RTL and testbench

ROW_MATRIX_STREAM_PU -- requirements
Module: row_matrix_stream_pu

---
 rtl/row_matrix_stream_pu.sv | 143 ++++++++++++++
 tb/tb_row_matrix_stream_pu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/row_matrix_stream_pu.sv
// Streaming row-by-matrix MAC: each accepted element is multiplied by a weight row
// across WEIGHT_COL lanes, accumulated over the job, then clamped and presented.
module row_matrix_stream_pu #(
    parameter int OP1_WIDTH    = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int WEIGHT_COL   = 4,
    parameter int ACC_WIDTH    = 24,
    parameter int OUT_WIDTH    = 16,
    parameter int DEPTH        = 64,
    parameter int MAX_ROWS     = 16
) (
    input  logic                               CLK,
    input  logic                               n_rst,
    input  logic                               start,
    input  logic [$clog2(DEPTH)-1:0]           base_addr,
    input  logic [$clog2(MAX_ROWS)-1:0]        row_cnt,
    input  logic                               op1_valid,
    input  logic [OP1_WIDTH-1:0]               op1_data,
    output logic                               op1_ready,
    input  logic                               wt_we,
    input  logic [$clog2(DEPTH)-1:0]           wt_waddr,
    input  logic [WEIGHT_COL*WEIGHT_WIDTH-1:0] wt_wdata,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WEIGHT_COL*OUT_WIDTH-1:0]    out_data,
    output logic [WEIGHT_COL-1:0]              sat_flag,
    output logic                               busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(MAX_ROWS);
    localparam int PW = OP1_WIDTH + WEIGHT_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;
    state_t state, state_nxt;

    logic [WEIGHT_COL*WEIGHT_WIDTH-1:0] wmem [DEPTH];
    logic [WEIGHT_COL*WEIGHT_WIDTH-1:0] rd_row;
    logic [AW-1:0]                      ptr;
    logic [RW-1:0]                      cnt, row_cnt_r;
    logic signed [OP1_WIDTH-1:0]        op1_r;
    logic                               v1, v2;
    logic signed [PW-1:0]               prod [WEIGHT_COL];
    logic signed [ACC_WIDTH-1:0]        acc  [WEIGHT_COL];
    logic signed [WEIGHT_WIDTH-1:0]     wlane [WEIGHT_COL];
    logic [OUT_WIDTH-1:0]               clamp [WEIGHT_COL];
    logic [WEIGHT_COL-1:0]              clamp_hit;
    logic                               accept, last, drained;

    assign accept    = (state == LOAD) && op1_valid;
    assign last      = accept && (cnt == row_cnt_r);
    assign drained   = !v1 && !v2;
    assign op1_ready = (state == LOAD);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    // Weight store has no reset so contents survive n_rst
    always_ff @(posedge CLK) begin
        if (wt_we)
            wmem[wt_waddr] <= wt_wdata;
    end

    always_ff @(posedge CLK) begin
        if (n_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = LOAD;
            LOAD:    if (last)      state_nxt = DRAIN;
            DRAIN:   if (drained)   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned j = 0; j < WEIGHT_COL; j++) begin
            wlane[j]     = rd_row[j*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            clamp[j]     = acc[j][OUT_WIDTH-1:0];
            clamp_hit[j] = 1'b0;
            if (acc[j] > SAT_MAX) begin
                clamp[j]     = SAT_MAX[OUT_WIDTH-1:0];
                clamp_hit[j] = 1'b1;
            end else if (acc[j] < SAT_MIN) begin
                clamp[j]     = SAT_MIN[OUT_WIDTH-1:0];
                clamp_hit[j] = 1'b1;
            end
        end
    end

    // Read, multiply and accumulate each sit one edge apart, tagged by v1/v2
    always_ff @(posedge CLK) begin
        if (n_rst) begin
            ptr       <= '0;
            cnt       <= '0;
            row_cnt_r <= '0;
            op1_r     <= '0;
            rd_row    <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_data  <= '0;
            sat_flag  <= '0;
            for (int unsigned j = 0; j < WEIGHT_COL; j++) begin
                prod[j] <= '0;
                acc[j]  <= '0;
            end
        end else begin
            v1 <= accept;
            v2 <= v1;
            if (state == IDLE && start) begin
                row_cnt_r <= row_cnt;
                ptr       <= base_addr;
                cnt       <= '0;
                for (int unsigned j = 0; j < WEIGHT_COL; j++)
                    acc[j] <= '0;
            end
            if (accept) begin
                op1_r  <= op1_data;
                rd_row <= wmem[ptr];
                ptr    <= (ptr == AW'(DEPTH-1)) ? '0 : ptr + 1'b1;
                cnt    <= cnt + 1'b1;
            end
            for (int unsigned j = 0; j < WEIGHT_COL; j++) begin
                if (v1)
                    prod[j] <= PW'(op1_r) * PW'(wlane[j]);
                if (v2)
                    acc[j] <= acc[j] + ACC_WIDTH'(prod[j]);
            end
            if (state == DRAIN && drained) begin
                for (int unsigned j = 0; j < WEIGHT_COL; j++)
                    out_data[j*OUT_WIDTH +: OUT_WIDTH] <= clamp[j];
                sat_flag <= clamp_hit;
            end
        end
    end
endmodule

// File: tb/tb_row_matrix_stream_pu.sv
// Bench for row_matrix_stream_pu: directed and random jobs against a sum-of-products model.
module tb_row_matrix_stream_pu;
    logic        CLK = 1'b0;
    logic        n_rst, start, op1_valid, op1_ready, wt_we;
    logic        out_valid, out_ready, busy;
    logic [5:0]  base_addr, wt_waddr;
    logic [3:0]  row_cnt, sat_flag;
    logic [7:0]  op1_data;
    logic [31:0] wt_wdata;
    logic [63:0] out_data;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] wmem_m [64];
    logic [63:0] exp_data_q [$];
    logic [3:0]  exp_sat_q  [$];

    always #5 CLK = ~CLK;

    row_matrix_stream_pu #(
        .OP1_WIDTH(8), .WEIGHT_WIDTH(8), .WEIGHT_COL(4), .ACC_WIDTH(24),
        .OUT_WIDTH(16), .DEPTH(64), .MAX_ROWS(16)
    ) dut (
        .CLK(CLK), .n_rst(n_rst), .start(start), .base_addr(base_addr),
        .row_cnt(row_cnt), .op1_valid(op1_valid), .op1_data(op1_data),
        .op1_ready(op1_ready), .wt_we(wt_we), .wt_waddr(wt_waddr),
        .wt_wdata(wt_wdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sat_flag(sat_flag), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Result of a job: dot product of elements with the rows they hit, clamped per lane
    function automatic void model(input int base, input int rc, input int el[16],
                                  output logic [63:0] d, output logic [3:0] s);
        longint sum;
        logic signed [23:0] a;
        logic [31:0] row;
        byte w;
        d = '0;
        s = '0;
        for (int j = 0; j < 4; j++) begin
            sum = 0;
            for (int k = 0; k <= rc; k++) begin
                row = wmem_m[(base + k) % 64];
                w   = row[j*8 +: 8];
                sum += longint'(el[k]) * longint'(w);
            end
            a = sum[23:0];
            if (a > 32767) begin
                d[j*16 +: 16] = 16'h7fff; s[j] = 1'b1;
            end else if (a < -32768) begin
                d[j*16 +: 16] = 16'h8000; s[j] = 1'b1;
            end else begin
                d[j*16 +: 16] = a[15:0];
            end
        end
    endfunction

    // Compare process: any visible result must match the job at the head of the queue
    always @(negedge CLK) begin
        if (out_valid) begin
            if (exp_data_q.size() == 0) begin
                check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                check("out_data", out_data, exp_data_q[0]);
                check("sat_flag", {60'd0, sat_flag}, {60'd0, exp_sat_q[0]});
            end
        end
    end

    always @(posedge CLK) begin
        if (out_valid && out_ready && exp_data_q.size() > 0) begin
            void'(exp_data_q.pop_front());
            void'(exp_sat_q.pop_front());
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    task automatic write_row(input int a, input logic [31:0] d);
        @(posedge CLK); #1;
        wt_we = 1'b1; wt_waddr = 6'(a); wt_wdata = d;
        @(posedge CLK); #1;
        wt_we = 1'b0;
        wmem_m[a] = d;
    endtask

    // mode: 0 = back-to-back, 1 = valid pattern 1,0,0,1,..., 2 = random bubbles
    task automatic run_job(input int base, input int rc, input int el[16], input int mode,
                           input int hold, input bit start_in_wait, input bit collide,
                           output logic [63:0] md, output logic [3:0] ms);
        int k, guard, cyc, n;
        bit v, rdy, wrote;
        model(base, rc, el, md, ms);
        exp_data_q.push_back(md);
        exp_sat_q.push_back(ms);
        @(posedge CLK); #1;
        start = 1'b1; base_addr = 6'(base); row_cnt = 4'(rc);
        @(posedge CLK); #1;
        start = 1'b0;
        check("busy_in_load", {63'd0, busy}, 64'd1);
        k = 0; guard = 0; cyc = 0; wrote = 1'b0;
        while (k <= rc && guard < 300) begin
            case (mode)
                0:       op1_valid = 1'b1;
                1:       op1_valid = (cyc % 3 == 0);
                default: op1_valid = 1'($urandom_range(0, 1));
            endcase
            op1_data = 8'(el[k]);
            if (collide && cyc == 0) begin
                wt_we = 1'b1; wt_waddr = 6'(base); wt_wdata = ~wmem_m[base]; wrote = 1'b1;
            end
            v = op1_valid; rdy = op1_ready;
            @(posedge CLK);
            if (v && rdy) k++;
            #1;
            if (wrote) begin
                wt_we = 1'b0; wmem_m[base] = wt_wdata; wrote = 1'b0;
            end
            cyc++; guard++;
        end
        op1_valid = 1'b0;
        check("accept_count", 64'(k), 64'(rc + 1));
        check("ready_after_load", {63'd0, op1_ready}, 64'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge CLK); #1; n++;
        end
        check("out_latency", 64'(n), 64'd3);
        for (int h = 0; h < hold; h++) begin
            if (start_in_wait && h == 1) begin
                start = 1'b1; base_addr = 6'($urandom_range(0, 63)); row_cnt = 4'($urandom_range(0, 15));
            end
            @(posedge CLK); #1;
            start = 1'b0;
            check("busy_while_held", {63'd0, busy}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        check("valid_drop", {63'd0, out_valid}, 64'd0);
        check("idle_after_hs", {63'd0, busy}, 64'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ready"}, {63'd0, op1_ready}, 64'd0);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_busy"},  {63'd0, busy}, 64'd0);
        check({tag, "_data"},  out_data, 64'd0);
        check({tag, "_sat"},   {60'd0, sat_flag}, 64'd0);
    endtask

    initial begin
        int el[16];
        logic [63:0] md;
        logic [3:0] ms;
        int rc;
        n_rst = 1'b1; start = 1'b0; op1_valid = 1'b0; op1_data = '0; wt_we = 1'b0;
        wt_waddr = '0; wt_wdata = '0; out_ready = 1'b0; base_addr = '0; row_cnt = '0;
        for (int a = 0; a < 64; a++) write_row(a, $urandom);
        write_row(0, {4{8'd1}});
        write_row(1, {4{8'd2}});
        check_cleared("reset");

        // Start on the first non-reset edge, then reset again after one accept
        n_rst = 1'b0; start = 1'b1; base_addr = 6'd0; row_cnt = 4'd1;
        @(posedge CLK); #1;
        start = 1'b0;
        check("start_after_reset", {63'd0, busy}, 64'd1);
        op1_valid = 1'b1; op1_data = 8'd3;
        @(posedge CLK); #1;
        op1_valid = 1'b0; n_rst = 1'b1;
        @(posedge CLK); #1;
        n_rst = 1'b0;
        check_cleared("mid_load_reset");

        el = '{default: 0}; el[0] = 3; el[1] = 4;
        run_job(0, 1, el, 0, 0, 1'b0, 1'b0, md, ms);
        check("model_basic", md, {4{16'd11}});
        run_job(0, 1, el, 1, 0, 1'b0, 1'b0, md, ms);
        check("model_bubbles", md, {4{16'd11}});
        run_job(0, 1, el, 0, 5, 1'b1, 1'b0, md, ms);

        for (int a = 0; a < 4; a++) write_row(a, {4{8'd127}});
        el = '{default: 0};
        for (int k = 0; k < 4; k++) el[k] = 127;
        run_job(0, 3, el, 0, 0, 1'b0, 1'b0, md, ms);
        check("model_sat_pos", {ms, md}, {4'hf, {4{16'h7fff}}});
        for (int k = 0; k < 4; k++) el[k] = -128;
        run_job(0, 3, el, 0, 1, 1'b0, 1'b0, md, ms);
        check("model_sat_neg", {ms, md}, {4'hf, {4{16'h8000}}});

        write_row(63, {4{8'd1}});
        write_row(0, {4{8'd5}});
        el = '{default: 0}; el[0] = 2; el[1] = 2;
        run_job(63, 1, el, 0, 0, 1'b0, 1'b0, md, ms);
        check("model_wrap", md, {4{16'd12}});
        // Same-edge write to the row being read must not affect this job
        run_job(63, 1, el, 0, 0, 1'b0, 1'b1, md, ms);

        for (int t = 0; t < 30; t++) begin
            for (int w = 0; w < 3; w++) write_row($urandom_range(0, 63), $urandom);
            rc = $urandom_range(0, 15);
            el = '{default: 0};
            for (int k = 0; k <= rc; k++) el[k] = $urandom_range(0, 255) - 128;
            run_job($urandom_range(0, 63), rc, el, 2, $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), 1'b0, md, ms);
        end

        check("queue_drained", 64'(exp_data_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
